serial_frame_sequencer: RTL and testbench



---
 rtl/serial_pkg.sv | 19 +
 rtl/serial_frame_sequencer_bit_timer.sv | 30 +++
 rtl/serial_frame_sequencer.sv | 114 +++++++++++
 tb/tb_serial_frame_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared types and constants for the framed serial transmitter.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;

  // A one-cycle bit period still needs a 1-bit counter.
  function automatic int timer_width(input int clks);
    return (clks <= 2) ? 1 : $clog2(clks);
  endfunction

endpackage

// File: rtl/serial_frame_sequencer_bit_timer.sv
// Bit-period down-counter: reload on clear, terminal count when it reaches zero.
module bit_timer
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int WIDTH        = timer_width(CLKS_PER_BIT)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  output logic o_tc
);

  localparam logic [WIDTH-1:0] LOAD = WIDTH'(CLKS_PER_BIT - 1);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= LOAD;
    end else if (r_count != '0) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_tc = (r_count == '0);

endmodule

// File: rtl/serial_frame_sequencer.sv
// Accepts a byte per handshake and shifts it out as a start/8 data/stop frame,
// exposing the bit-select index that drives the downstream 8:1 mux.
module serial_frame_sequencer
  import serial_pkg::*;
#(
  parameter int   CLKS_PER_BIT = 4,
  parameter logic MSB_FIRST    = 1'b0,
  parameter logic IDLE_LEVEL   = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [2:0] sel,
  output logic [7:0] data_q,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] SEL_FIRST = MSB_FIRST ? 3'd7 : 3'd0;
  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

  state_t     r_state;
  logic [2:0] r_bit_cnt;
  logic [2:0] r_sel;
  logic [7:0] r_data_q;
  logic       r_tx;
  logic       r_in_ready;
  logic       r_busy;
  logic       r_done;

  logic       w_tc;
  logic       w_timer_clear;
  logic [2:0] w_sel_next;

  // Timer is held loaded while idle so START gets a full bit period.
  assign w_timer_clear = (r_state == IDLE) || w_tc;
  assign w_sel_next    = MSB_FIRST ? (r_sel - 3'd1) : (r_sel + 3'd1);

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clear(w_timer_clear),
    .o_tc   (w_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_bit_cnt  <= 3'd0;
      r_sel      <= 3'd0;
      r_data_q   <= 8'd0;
      r_tx       <= IDLE_LEVEL;
      r_in_ready <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_data_q   <= in_data;
            r_sel      <= SEL_FIRST;
            r_bit_cnt  <= 3'd0;
            r_tx       <= ~IDLE_LEVEL;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= START;
          end
        end
        START: begin
          if (w_tc) begin
            r_state <= DATA;
            r_tx    <= r_data_q[r_sel];
          end
        end
        DATA: begin
          if (w_tc) begin
            // sel parks on the final index until the next handshake reloads it.
            if (r_bit_cnt == LAST_BIT) begin
              r_state <= STOP;
              r_tx    <= IDLE_LEVEL;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              r_sel     <= w_sel_next;
              r_tx      <= r_data_q[w_sel_next];
            end
          end
        end
        STOP: begin
          if (w_tc) begin
            r_state    <= IDLE;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready = r_in_ready;
  assign sel      = r_sel;
  assign data_q   = r_data_q;
  assign tx       = r_tx;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_serial_frame_sequencer.sv
// Scoreboard bench: three instances (LSB-first/4, MSB-first/4, LSB-first/1 clocks per bit).
module tb_serial_frame_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [2:0][7:0] in_data;
  logic [2:0]      in_valid;
  wire  [2:0]      in_ready;
  wire  [2:0]      tx;
  wire  [2:0]      busy;
  wire  [2:0]      done;
  wire  [2:0][2:0] sel;
  wire  [2:0][7:0] data_q;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_acc = 0;

  typedef struct packed {
    logic       tx;
    logic [2:0] sel;
    logic       done;
    logic       busy;
    logic       rdy;
    logic [7:0] dq;
  } exp_t;

  exp_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  serial_frame_sequencer #(.CLKS_PER_BIT(4), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_lsb (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .sel(sel[0]), .data_q(data_q[0]), .tx(tx[0]),
    .busy(busy[0]), .done(done[0])
  );

  serial_frame_sequencer #(.CLKS_PER_BIT(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .sel(sel[1]), .data_q(data_q[1]), .tx(tx[1]),
    .busy(busy[1]), .done(done[1])
  );

  serial_frame_sequencer #(.CLKS_PER_BIT(1), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_fast (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[2]), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .sel(sel[2]), .data_q(data_q[2]), .tx(tx[2]),
    .busy(busy[2]), .done(done[2])
  );

  function automatic int cpb_of(input int k);
    return (k == 2) ? 1 : 4;
  endfunction

  function automatic bit msb_of(input int k);
    return (k == 1);
  endfunction

  // Sends byte b on instance k and checks every cycle through the done pulse.
  // cont: valid/data already presented at this negedge; chain: keep valid high
  // and present nb on the done cycle; pulse_at: cycle to flash a 0xFF byte.
  task automatic drive_frame(input int k, input logic [7:0] b, input bit cont,
                             input bit chain, input logic [7:0] nb, input int pulse_at);
    int   n;
    int   bi;
    int   idx;
    exp_t e;
    exp_t got;
    logic [2:0] first_sel;
    logic [2:0] last_sel;
    n         = cpb_of(k);
    first_sel = msb_of(k) ? 3'd7 : 3'd0;
    last_sel  = msb_of(k) ? 3'd0 : 3'd7;
    if (!cont) @(negedge clk);
    in_valid[k] = 1'b1;
    in_data[k]  = b;
    checks++;
    if (in_ready[k] !== 1'b1) begin
      failures++;
      $display("FAIL ready_before_accept k=%0d got=%b exp=1", k, in_ready[k]);
    end
    @(posedge clk);
    #1;
    last_acc = cyc;
    if (!chain) begin
      in_valid[k] = 1'b0;
      in_data[k]  = ~b;
    end
    for (int c = 0; c <= 10 * n; c++) begin
      bi     = c / n;
      e.dq   = b;
      e.done = 1'b0;
      e.busy = 1'b1;
      e.rdy  = 1'b0;
      if (c == 10 * n) begin
        e.tx = 1'b1; e.sel = last_sel; e.done = 1'b1; e.busy = 1'b0; e.rdy = 1'b1;
      end else if (bi == 0) begin
        e.tx = 1'b0; e.sel = first_sel;
      end else if (bi <= 8) begin
        idx   = msb_of(k) ? (8 - bi) : (bi - 1);
        e.tx  = b[idx];
        e.sel = idx[2:0];
      end else begin
        e.tx = 1'b1; e.sel = last_sel;
      end
      exp_q.push_back(e);
    end
    for (int c = 0; c <= 10 * n; c++) begin
      @(negedge clk);
      e   = exp_q.pop_front();
      got = {tx[k], sel[k], done[k], busy[k], in_ready[k], data_q[k]};
      checks++;
      if (got.tx !== e.tx) begin
        failures++;
        $display("FAIL tx k=%0d byte=%h c=%0d got=%b exp=%b", k, b, c, got.tx, e.tx);
      end
      checks++;
      if (got[13:0] !== e[13:0]) begin
        failures++;
        $display("FAIL status k=%0d byte=%h c=%0d got sel=%0d done=%b busy=%b rdy=%b dq=%h exp sel=%0d done=%b busy=%b rdy=%b dq=%h",
                 k, b, c, got.sel, got.done, got.busy, got.rdy, got.dq,
                 e.sel, e.done, e.busy, e.rdy, e.dq);
      end
      if (pulse_at >= 0 && c == pulse_at) begin
        in_valid[k] = 1'b1;
        in_data[k]  = 8'hFF;
      end
      if (pulse_at >= 0 && c == pulse_at + 1) in_valid[k] = 1'b0;
      if (chain && c == 10 * n) in_data[k] = nb;
    end
    $display("frame k=%0d byte=%h accepted at cycle %0d", k, b, last_acc);
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = '0;
    in_data  = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({tx[k], sel[k], done[k], busy[k], in_ready[k], data_q[k]} !== {1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 8'h00}) begin
        failures++;
        $display("FAIL reset_state k=%0d got tx=%b sel=%0d done=%b busy=%b rdy=%b dq=%h exp 1/0/0/0/1/00",
                 k, tx[k], sel[k], done[k], busy[k], in_ready[k], data_q[k]);
      end
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    $display("reset released at cycle %0d", cyc);
  endtask

  task automatic test_lsb_first();
    drive_frame(0, 8'hA5, 1'b0, 1'b0, 8'h00, -1);
  endtask

  task automatic test_back_to_back();
    int a1;
    drive_frame(0, 8'h00, 1'b0, 1'b1, 8'hFF, -1);
    a1 = last_acc;
    drive_frame(0, 8'hFF, 1'b1, 1'b0, 8'h00, -1);
    checks++;
    if (last_acc - a1 !== 41) begin
      failures++;
      $display("FAIL b2b_spacing got=%0d exp=41", last_acc - a1);
    end
  endtask

  task automatic test_msb_first();
    drive_frame(1, 8'h80, 1'b0, 1'b0, 8'h00, -1);
  endtask

  task automatic test_single_cycle_bits();
    drive_frame(2, 8'h3C, 1'b0, 1'b0, 8'h00, -1);
  endtask

  task automatic test_abort();
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_data[0]  = 8'h55;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    repeat (15) @(negedge clk);
    checks++;
    if (busy[0] !== 1'b1) begin
      failures++;
      $display("FAIL abort_pre_busy got=%b exp=1", busy[0]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({tx[0], busy[0], in_ready[0], done[0], data_q[0]} !== {1'b1, 1'b0, 1'b1, 1'b0, 8'h00}) begin
      failures++;
      $display("FAIL abort_immediate got tx=%b busy=%b rdy=%b done=%b dq=%h exp 1/0/1/0/00",
               tx[0], busy[0], in_ready[0], done[0], data_q[0]);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (done[0] !== 1'b0) begin
        failures++;
        $display("FAIL abort_no_done i=%0d got=%b exp=0", i, done[0]);
      end
    end
    rst_n = 1'b1;
    $display("abort reset released at cycle %0d", cyc);
    drive_frame(0, 8'h3A, 1'b0, 1'b0, 8'h00, -1);
  endtask

  task automatic test_ignore_mid_frame();
    drive_frame(0, 8'h12, 1'b0, 1'b0, 8'h00, 17);
  endtask

  initial begin
    test_reset();
    test_lsb_first();
    test_back_to_back();
    test_msb_first();
    test_single_cycle_bits();
    test_abort();
    test_ignore_mid_frame();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
